replica_sink: RTL and testbench

- Receiving end of the replica shift chain: consumes the beat stream leaving the last replica_ram during shift-out.
- Stream format: one beat per cycle, LANES city indices per beat, CITY_BEATS beats per replica, REPLICA_NUM replicas back-to-back.
- Per replica: checks the tour is a permutation of 0..LANES*CITY_BEATS-1 and computes first city and checksum.
- Results go to a host through a 2-deep valid/ready result FIFO.

---
 rtl/replica_sink.sv | 215 +++++++++++++++++++++
 tb/tb_replica_sink.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/replica_sink.sv
// Receiving end of the replica shift chain: checks each replica's tour is a
// permutation, computes first city and checksum, and queues results for the host.
module replica_sink #(
  parameter int LANES       = 8,
  parameter int NODE_W      = 7,
  parameter int CITY_BEATS  = 4,
  parameter int REPLICA_NUM = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           in_valid,
  input  logic [LANES*NODE_W-1:0]        in_data,
  output logic                           busy,
  output logic                           done,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [$clog2(REPLICA_NUM)-1:0] res_replica,
  output logic                           res_ok,
  output logic [NODE_W-1:0]              res_first,
  output logic [15:0]                    res_sum,
  output logic [2:0]                     err
);

  localparam int NCITY = LANES * CITY_BEATS;
  localparam int RW    = $clog2(REPLICA_NUM);
  localparam int BW    = (CITY_BEATS > 1) ? $clog2(CITY_BEATS) : 1;
  localparam logic [NODE_W:0] NCITY_EXT = (NODE_W + 1)'(NCITY);

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  typedef struct packed {
    logic [RW-1:0]     rep;
    logic              ok;
    logic [NODE_W-1:0] first;
    logic [15:0]       sum;
  } result_t;

  state_t                state_q, state_d;
  logic [BW-1:0]         beat_cnt_q, beat_cnt_d;
  logic [RW-1:0]         rep_cnt_q, rep_cnt_d;
  logic [2**NODE_W-1:0]  bitmap_q, bitmap_d;
  logic                  dup_q, dup_d;
  logic [15:0]           sum_q, sum_d;
  logic [NODE_W-1:0]     first_q, first_d;
  logic [2:0]            err_q, err_d;
  result_t               fifo_q [2];
  result_t               fifo_d [2];
  logic [1:0]            cnt_q, cnt_d;

  logic [NODE_W-1:0]     lane [LANES];
  logic                  beat_dup;
  logic [15:0]           beat_sum;
  logic [2**NODE_W-1:0]  beat_bits;
  logic [NODE_W-1:0]     first_beat;
  logic                  last_beat, last_rep;
  logic                  push, pop, ovf_d;
  logic [1:0]            err_lo_d;
  result_t               push_data;

  always_comb begin
    for (int i = 0; i < LANES; i++) lane[i] = in_data[i*NODE_W +: NODE_W];
  end

  // Out-of-range indices are flagged but never marked, so the bitmap only
  // ever holds legal cities.
  always_comb begin
    beat_dup  = 1'b0;
    beat_sum  = sum_q;
    beat_bits = bitmap_q;
    for (int i = 0; i < LANES; i++) begin
      if ({1'b0, lane[i]} >= NCITY_EXT) begin
        beat_dup = 1'b1;
      end else begin
        if (bitmap_q[lane[i]]) beat_dup = 1'b1;
        beat_bits[lane[i]] = 1'b1;
      end
      beat_sum = beat_sum + 16'(lane[i]);
      for (int j = i + 1; j < LANES; j++) begin
        if (lane[i] == lane[j]) beat_dup = 1'b1;
      end
    end
  end

  assign first_beat = (beat_cnt_q == '0) ? lane[0] : first_q;
  assign last_beat  = (beat_cnt_q == BW'(CITY_BEATS - 1));
  assign last_rep   = (rep_cnt_q == RW'(REPLICA_NUM - 1));

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    bitmap_d   = bitmap_q;
    dup_d      = dup_q;
    sum_d      = sum_q;
    first_d    = first_q;
    err_lo_d   = err_q[1:0];
    push       = 1'b0;
    push_data  = '0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) err_lo_d[0] = 1'b1;
        if (start) begin
          state_d    = RECV;
          beat_cnt_d = '0;
          rep_cnt_d  = '0;
          bitmap_d   = '0;
          dup_d      = 1'b0;
          sum_d      = '0;
        end
      end
      RECV: begin
        if (start) err_lo_d[1] = 1'b1;
        if (in_valid) begin
          if (last_beat) begin
            push            = 1'b1;
            push_data.rep   = rep_cnt_q;
            push_data.ok    = ~(dup_q | beat_dup);
            push_data.first = first_beat;
            push_data.sum   = beat_sum;
            bitmap_d        = '0;
            dup_d           = 1'b0;
            sum_d           = '0;
            beat_cnt_d      = '0;
            rep_cnt_d       = last_rep ? '0 : rep_cnt_q + RW'(1);
            if (last_rep) state_d = DONE;
          end else begin
            bitmap_d   = beat_bits;
            dup_d      = dup_q | beat_dup;
            sum_d      = beat_sum;
            first_d    = first_beat;
            beat_cnt_d = beat_cnt_q + BW'(1);
          end
        end
      end
      DONE: begin
        if (in_valid) err_lo_d[0] = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop = res_valid & res_ready;

  // Head entry always lives in slot 0 so the result outputs come straight from flops.
  always_comb begin
    fifo_d = fifo_q;
    cnt_d  = cnt_q;
    ovf_d  = err_q[2];
    unique case ({push, pop})
      2'b11: begin
        if (cnt_q == 2'd2) begin
          fifo_d[0] = fifo_q[1];
          fifo_d[1] = push_data;
        end else begin
          fifo_d[0] = push_data;
        end
      end
      2'b10: begin
        if (cnt_q == 2'd2) begin
          ovf_d = 1'b1;
        end else begin
          fifo_d[cnt_q[0]] = push_data;
          cnt_d            = cnt_q + 2'd1;
        end
      end
      2'b01: begin
        fifo_d[0] = fifo_q[1];
        cnt_d     = cnt_q - 2'd1;
      end
      default: ;
    endcase
  end

  assign err_d = {ovf_d, err_lo_d};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      rep_cnt_q  <= '0;
      bitmap_q   <= '0;
      dup_q      <= 1'b0;
      sum_q      <= '0;
      first_q    <= '0;
      err_q      <= '0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      bitmap_q   <= bitmap_d;
      dup_q      <= dup_d;
      sum_q      <= sum_d;
      first_q    <= first_d;
      err_q      <= err_d;
      fifo_q[0]  <= fifo_d[0];
      fifo_q[1]  <= fifo_d[1];
      cnt_q      <= cnt_d;
    end
  end

  assign busy        = (state_q == RECV);
  assign done        = (state_q == DONE);
  assign res_valid   = (cnt_q != 2'd0);
  assign res_replica = fifo_q[0].rep;
  assign res_ok      = fifo_q[0].ok;
  assign res_first   = fifo_q[0].first;
  assign res_sum     = fifo_q[0].sum;
  assign err         = err_q;

endmodule

// File: tb/tb_replica_sink.sv
// Testbench for replica_sink: drives shift-out streams and checks each result
// against a permutation/checksum reference model through a scoreboard queue.
module tb_replica_sink;

   localparam int LANES       = 8;
   localparam int NODE_W      = 7;
   localparam int CITY_BEATS  = 4;
   localparam int REPLICA_NUM = 4;
   localparam int NCITY       = LANES * CITY_BEATS;
   localparam int NVAL        = 1 << NODE_W;
   localparam int RW          = $clog2(REPLICA_NUM);

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0;
   logic inValid = 1'b0;
   logic resReady = 1'b0;
   logic [LANES*NODE_W-1:0] inData = '0;
   logic busy, done, resValid, resOk;
   logic [RW-1:0] resReplica;
   logic [NODE_W-1:0] resFirst;
   logic [15:0] resSum;
   logic [2:0] err;

   typedef struct {
      int rep;
      bit ok;
      int first;
      int sum;
   } exp_t;

   exp_t expQ[$];
   exp_t monEntry;
   int tourMem [REPLICA_NUM][NCITY];
   logic [2:0] expErr = '0;
   int compared = 0;
   int mismatched = 0;
   bit randReady = 1'b0;

   // Free-running clock, 10 time units per cycle
   always #5 clk = ~clk;

   replica_sink #(
      .LANES(LANES), .NODE_W(NODE_W), .CITY_BEATS(CITY_BEATS), .REPLICA_NUM(REPLICA_NUM)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(inValid), .in_data(inData),
      .busy(busy), .done(done), .res_valid(resValid), .res_ready(resReady),
      .res_replica(resReplica), .res_ok(resOk), .res_first(resFirst), .res_sum(resSum),
      .err(err)
   );

   // One comparison: bumps the counters and reports any difference
   task automatic checkOutput(input string name, input int actual, input int expected);
      compared++;
      if (actual != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Advance to just after the next rising edge; optionally randomise the host ready
   task automatic step();
      @(posedge clk);
      #1;
      if (randReady) resReady = 1'($urandom_range(0, 1));
   endtask

   // Build a replica tour: 0 identity, 1 shuffled, 2 shuffled with a random in-range
   // overwrite, 3 shuffled with an out-of-range city
   task automatic makeTour(input int r, input int mode);
      int tmp;
      int k;
      for (int c = 0; c < NCITY; c++) tourMem[r][c] = c;
      if (mode >= 1) begin
         for (int c = NCITY - 1; c > 0; c--) begin
            k = int'($urandom_range(0, c));
            tmp = tourMem[r][c];
            tourMem[r][c] = tourMem[r][k];
            tourMem[r][k] = tmp;
         end
      end
      if (mode == 2) tourMem[r][$urandom_range(0, NCITY - 1)] = int'($urandom_range(0, NCITY - 1));
      if (mode == 3) tourMem[r][$urandom_range(0, NCITY - 1)] = int'($urandom_range(NCITY, NVAL - 1));
   endtask

   task automatic identityAll();
      for (int r = 0; r < REPLICA_NUM; r++) makeTour(r, 0);
   endtask

   function automatic logic [LANES*NODE_W-1:0] packBeat(input int r, input int b);
      logic [LANES*NODE_W-1:0] d;
      d = '0;
      for (int i = 0; i < LANES; i++) d[i*NODE_W +: NODE_W] = NODE_W'(tourMem[r][b*LANES + i]);
      return d;
   endfunction

   // Reference model: a tour is ok when every city 0..NCITY-1 appears exactly once;
   // the expectation queue stands in for the two-entry result buffer
   task automatic modelPush(input int r);
      int seen[NVAL];
      exp_t e;
      foreach (seen[v]) seen[v] = 0;
      e.rep = r;
      e.ok = 1'b1;
      e.first = tourMem[r][0];
      e.sum = 0;
      for (int c = 0; c < NCITY; c++) begin
         e.sum = (e.sum + tourMem[r][c]) % 65536;
         if (tourMem[r][c] >= NCITY) e.ok = 1'b0;
         else seen[tourMem[r][c]]++;
      end
      for (int v = 0; v < NCITY; v++) if (seen[v] != 1) e.ok = 1'b0;
      if (expQ.size() == 2) expErr[2] = 1'b1;
      else expQ.push_back(e);
   endtask

   // Start, stream every replica of tourMem, then check the done pulse
   task automatic applyStimulus(input bit misuseStart, input bit gaps, input int readyOnRep);
      start = 1'b1;
      step();
      start = 1'b0;
      checkOutput("busy_after_start", int'(busy), 1);
      for (int r = 0; r < REPLICA_NUM; r++) begin
         for (int b = 0; b < CITY_BEATS; b++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
               inValid = 1'b0;
               step();
            end
            inValid = 1'b1;
            inData = packBeat(r, b);
            if (misuseStart && r == 1 && b == 2) begin
               start = 1'b1;
               expErr[1] = 1'b1;
            end
            if (r == readyOnRep && b == CITY_BEATS - 1) resReady = 1'b1;
            step();
            start = 1'b0;
            if (b == CITY_BEATS - 1) modelPush(r);
            if (!(r == REPLICA_NUM - 1 && b == CITY_BEATS - 1))
               checkOutput("busy_in_stream", int'(busy), 1);
         end
      end
      inValid = 1'b0;
      checkOutput("done_pulse", int'(done), 1);
      checkOutput("busy_in_done", int'(busy), 0);
      step();
      checkOutput("done_clear", int'(done), 0);
      checkOutput("busy_idle", int'(busy), 0);
   endtask

   // Let the host take everything, then confirm nothing is left and flags agree
   task automatic drain();
      randReady = 1'b0;
      resReady = 1'b1;
      repeat (6) step();
      checkOutput("results_left", expQ.size(), 0);
      checkOutput("err_flags", int'(err), int'(expErr));
   endtask

   task automatic doReset();
      reset = 1'b0;
      inValid = 1'b0;
      start = 1'b0;
      expQ.delete();
      expErr = '0;
      step();
      reset = 1'b1;
      step();
      checkOutput("err_after_reset", int'(err), 0);
   endtask

   // Monitor: each handshake pops the oldest expectation and compares it with the head
   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            checkOutput("res_valid", int'(resValid), int'(expQ.size() != 0));
            if (resValid && resReady) begin
               if (expQ.size() == 0) begin
                  checkOutput("unexpected_result", 1, 0);
               end else begin
                  monEntry = expQ.pop_front();
                  checkOutput("res_replica", int'(resReplica), monEntry.rep);
                  checkOutput("res_ok", int'(resOk), int'(monEntry.ok));
                  checkOutput("res_first", int'(resFirst), monEntry.first);
                  checkOutput("res_sum", int'(resSum), monEntry.sum);
               end
            end
         end
      end
   end

   // Main sequence: directed scenarios first, then randomised shift-outs
   initial begin
      #12;
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_done", int'(done), 0);
      checkOutput("rst_valid", int'(resValid), 0);
      checkOutput("rst_sum", int'(resSum), 0);
      checkOutput("rst_err", int'(err), 0);
      step();
      reset = 1'b1;
      step();

      $display("[TB] identity stream");
      identityAll();
      resReady = 1'b1;
      applyStimulus(1'b0, 1'b0, -1);
      drain();

      $display("[TB] duplicate city in replica 1");
      identityAll();
      tourMem[1][2*LANES + 3] = 5;
      applyStimulus(1'b0, 1'b0, -1);
      drain();

      $display("[TB] intra-beat collision and out-of-range city");
      identityAll();
      tourMem[0][1*LANES + 0] = 9;
      tourMem[2][3*LANES + 7] = 40;
      applyStimulus(1'b0, 1'b0, -1);
      drain();

      $display("[TB] backpressure overflow");
      doReset();
      identityAll();
      resReady = 1'b0;
      applyStimulus(1'b0, 1'b0, -1);
      checkOutput("bp_overflow", int'(err[2]), 1);
      checkOutput("bp_valid", int'(resValid), 1);
      drain();

      $display("[TB] push and pop while full");
      doReset();
      resReady = 1'b0;
      applyStimulus(1'b0, 1'b0, 2);
      drain();

      $display("[TB] stray beat and start while busy");
      doReset();
      inValid = 1'b1;
      inData = packBeat(0, 0);
      expErr[0] = 1'b1;
      step();
      inValid = 1'b0;
      checkOutput("err_stray", int'(err), 1);
      resReady = 1'b1;
      applyStimulus(1'b1, 1'b0, -1);
      drain();

      $display("[TB] reset in the middle of a stream");
      identityAll();
      resReady = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         inValid = 1'b1;
         inData = packBeat(k / CITY_BEATS, k % CITY_BEATS);
         step();
         if (k == CITY_BEATS - 1) modelPush(0);
      end
      reset = 1'b0;
      inValid = 1'b0;
      expQ.delete();
      expErr = '0;
      #1;
      checkOutput("mid_rst_busy", int'(busy), 0);
      checkOutput("mid_rst_valid", int'(resValid), 0);
      checkOutput("mid_rst_first", int'(resFirst), 0);
      checkOutput("mid_rst_sum", int'(resSum), 0);
      checkOutput("mid_rst_err", int'(err), 0);
      step();
      reset = 1'b1;
      step();
      resReady = 1'b1;
      applyStimulus(1'b0, 1'b0, -1);
      drain();

      $display("[TB] randomised tours with random host ready");
      for (int n = 0; n < 8; n++) begin
         doReset();
         for (int r = 0; r < REPLICA_NUM; r++) makeTour(r, int'($urandom_range(0, 3)));
         randReady = 1'b1;
         applyStimulus(1'b0, 1'b1, -1);
         drain();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
